// File: rtl/alarm_trigger_pkg.sv
// Shared alarm-clock definitions: time field widths, limits and the alarm FSM encoding.
package clock_pkg;
  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;
  localparam int TIME_W      = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;
endpackage

// File: rtl/alarm_trigger_if.sv
// Time/button inputs and buzzer/status outputs of the alarm trigger, bundled for the top port list.
interface alarm_trigger_if;
  import clock_pkg::*;

  logic              sec_tick;
  logic [TIME_W-1:0] cur_hour;
  logic [TIME_W-1:0] cur_minute;
  logic [TIME_W-1:0] alarm_hour;
  logic [TIME_W-1:0] alarm_minute;
  logic              alarm_set;
  logic              stop_signal;
  logic              snooze_signal;
  logic              buzzer;
  logic              ringing;
  logic              snoozing;
  logic [1:0]        snooze_count;

  modport master (
    output sec_tick, cur_hour, cur_minute, alarm_hour, alarm_minute,
           alarm_set, stop_signal, snooze_signal,
    input  buzzer, ringing, snoozing, snooze_count
  );

  modport slave (
    input  sec_tick, cur_hour, cur_minute, alarm_hour, alarm_minute,
           alarm_set, stop_signal, snooze_signal,
    output buzzer, ringing, snoozing, snooze_count
  );
endinterface

// File: rtl/alarm_trigger_button_release_detect.sv
// Registers one button level and flags the cycle in which it is released (1 -> 0).
module button_release_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic ev_o
);
  logic last_q;

  always_ff @(posedge clk) begin
    if (!reset) last_q <= 1'b0;
    else        last_q <= btn_i;
  end

  assign ev_o = last_q & ~btn_i;
endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: rings on the alarm-time match edge, handles stop/snooze/timeout and drives the buzzer.
module alarm_trigger
  import clock_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input logic            clk,
  input logic            reset,
  alarm_trigger_if.slave bus
);
  localparam int CNT_W = $clog2(RING_SECS > SNOOZE_SECS ? RING_SECS : SNOOZE_SECS);

  alarm_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       snz_q, snz_d;
  logic             buzzer_q, buzzer_d;
  logic             match_q;
  logic             match, trigger, stop_ev, snooze_ev;

  button_release_detect u_stop (
    .clk   (clk),
    .reset (reset),
    .btn_i (bus.stop_signal),
    .ev_o  (stop_ev)
  );

  button_release_detect u_snooze (
    .clk   (clk),
    .reset (reset),
    .btn_i (bus.snooze_signal),
    .ev_o  (snooze_ev)
  );

  assign match   = bus.alarm_set & (bus.cur_hour == bus.alarm_hour)
                 & (bus.cur_minute == bus.alarm_minute);
  assign trigger = match & ~match_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      snz_q    <= '0;
      buzzer_q <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snz_q    <= snz_d;
      buzzer_q <= buzzer_d;
      match_q  <= match;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snz_d    = snz_q;
    buzzer_d = buzzer_q;
    unique case (state_q)
      IDLE: begin
        buzzer_d = 1'b0;
        if (trigger) begin
          state_d  = RINGING;
          cnt_d    = '0;
          snz_d    = '0;
          buzzer_d = 1'b1;
        end
      end
      RINGING: begin
        // Buttons outrank a timeout tick arriving in the same cycle.
        if (!bus.alarm_set || stop_ev) begin
          state_d  = IDLE;
          cnt_d    = '0;
          buzzer_d = 1'b0;
        end else if (snooze_ev) begin
          cnt_d    = '0;
          buzzer_d = 1'b0;
          if (snz_q < 2'(MAX_SNOOZE)) begin
            state_d = SNOOZE;
            snz_d   = snz_q + 2'd1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.sec_tick) begin
          if (cnt_q == CNT_W'(RING_SECS - 1)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            buzzer_d = 1'b0;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            buzzer_d = ~buzzer_q;
          end
        end
      end
      SNOOZE: begin
        buzzer_d = 1'b0;
        if (!bus.alarm_set || stop_ev) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.sec_tick) begin
          if (cnt_q == CNT_W'(SNOOZE_SECS - 1)) begin
            state_d  = RINGING;
            cnt_d    = '0;
            buzzer_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        buzzer_d = 1'b0;
      end
    endcase
  end

  assign bus.buzzer       = buzzer_q;
  assign bus.ringing      = (state_q == RINGING);
  assign bus.snoozing     = (state_q == SNOOZE);
  assign bus.snooze_count = snz_q;
endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: ringing, snooze, snooze limit, timeout, button priority and reset.
module tb_alarm_trigger;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alarm_trigger_if bus ();

  alarm_trigger #(.RING_SECS(60), .SNOOZE_SECS(300), .MAX_SNOOZE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_tick = 1'b1;
      step();
      bus.sec_tick = 1'b0;
      step();
    end
  endtask

  task automatic release_snooze();
    bus.snooze_signal = 1'b1;
    step();
    bus.snooze_signal = 1'b0;
    step();
  endtask

  // status vector {ringing, snoozing, buzzer, snooze_count}
  function automatic logic [4:0] status();
    return {bus.ringing, bus.snoozing, bus.buzzer, bus.snooze_count};
  endfunction

  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b0;
    step();
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b000_00) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", obs, 5'b000_00);
    end
    reset = 1'b1;
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b000_00) begin
      n_fail++;
      $display("FAIL idle_no_match got=%b want=%b", obs, 5'b000_00);
    end
  endtask

  task automatic test_ring_pattern();
    logic [4:0] obs;
    logic       exp_buz [3];
    exp_buz = '{1'b0, 1'b1, 1'b0};
    bus.cur_minute = 7'd30;
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b101_00) begin
      n_fail++;
      $display("FAIL ring_on_match got=%b want=%b", obs, 5'b101_00);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (bus.buzzer !== exp_buz[i]) begin
        n_fail++;
        $display("FAIL buzzer_tick%0d got=%b want=%b", i + 1, bus.buzzer, exp_buz[i]);
      end
    end
  endtask

  task automatic test_snooze();
    logic [4:0] obs;
    release_snooze();
    obs = status();
    n_checks++;
    if (obs !== 5'b010_01) begin
      n_fail++;
      $display("FAIL snooze_enter got=%b want=%b", obs, 5'b010_01);
    end
    tick(299);
    obs = status();
    n_checks++;
    if (obs !== 5'b010_01) begin
      n_fail++;
      $display("FAIL snooze_299 got=%b want=%b", obs, 5'b010_01);
    end
    tick(1);
    obs = status();
    n_checks++;
    if (obs !== 5'b101_01) begin
      n_fail++;
      $display("FAIL snooze_rering got=%b want=%b", obs, 5'b101_01);
    end
  endtask

  task automatic test_max_snooze();
    logic [4:0] obs;
    for (int k = 2; k <= 3; k++) begin
      release_snooze();
      obs = status();
      n_checks++;
      if (obs !== {3'b010, 2'(k)}) begin
        n_fail++;
        $display("FAIL snooze%0d_enter got=%b want=%b", k, obs, {3'b010, 2'(k)});
      end
      tick(300);
      obs = status();
      n_checks++;
      if (obs !== {3'b101, 2'(k)}) begin
        n_fail++;
        $display("FAIL snooze%0d_rering got=%b want=%b", k, obs, {3'b101, 2'(k)});
      end
    end
    release_snooze();
    obs = status();
    n_checks++;
    if (obs !== 5'b000_11) begin
      n_fail++;
      $display("FAIL snooze4_stops got=%b want=%b", obs, 5'b000_11);
    end
  endtask

  task automatic test_timeout();
    logic [4:0] obs;
    bus.cur_minute = 7'd31;
    step();
    bus.alarm_minute = 7'd31;
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b101_00) begin
      n_fail++;
      $display("FAIL retrigger_clears_count got=%b want=%b", obs, 5'b101_00);
    end
    tick(59);
    n_checks++;
    if (bus.ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_59 ringing got=%b want=1", bus.ringing);
    end
    tick(1);
    obs = status();
    n_checks++;
    if (obs !== 5'b000_00) begin
      n_fail++;
      $display("FAIL timeout_60 got=%b want=%b", obs, 5'b000_00);
    end
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (bus.ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL no_retrigger ringing got=%b want=0", bus.ringing);
    end
  endtask

  task automatic test_tick_vs_button();
    logic [4:0] obs;
    bus.alarm_set = 1'b0;
    step();
    bus.alarm_set = 1'b1;
    step();
    tick(59);
    bus.snooze_signal = 1'b1;
    step();
    bus.sec_tick = 1'b1;
    bus.snooze_signal = 1'b0;
    step();
    bus.sec_tick = 1'b0;
    obs = status();
    n_checks++;
    if (obs !== 5'b010_01) begin
      n_fail++;
      $display("FAIL button_beats_timeout got=%b want=%b", obs, 5'b010_01);
    end
  endtask

  task automatic test_stop_and_snooze();
    logic [4:0] obs;
    tick(300);
    bus.stop_signal = 1'b1;
    bus.snooze_signal = 1'b1;
    step();
    bus.stop_signal = 1'b0;
    bus.snooze_signal = 1'b0;
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b000_01) begin
      n_fail++;
      $display("FAIL stop_beats_snooze got=%b want=%b", obs, 5'b000_01);
    end
  endtask

  task automatic test_drop_set();
    logic [4:0] obs;
    bus.alarm_set = 1'b0;
    step();
    bus.alarm_set = 1'b1;
    step();
    release_snooze();
    release_snooze();
    obs = status();
    n_checks++;
    if (obs !== 5'b010_01) begin
      n_fail++;
      $display("FAIL snooze_ignored_in_snooze got=%b want=%b", obs, 5'b010_01);
    end
    bus.alarm_set = 1'b0;
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b000_01) begin
      n_fail++;
      $display("FAIL drop_set_in_snooze got=%b want=%b", obs, 5'b000_01);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    bus.alarm_set = 1'b1;
    step();
    tick(1);
    n_checks++;
    if (status() !== 5'b100_00) begin
      n_fail++;
      $display("FAIL ring_before_reset got=%b want=%b", status(), 5'b100_00);
    end
    reset = 1'b0;
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b000_00) begin
      n_fail++;
      $display("FAIL reset_mid_ring got=%b want=%b", obs, 5'b000_00);
    end
    reset = 1'b1;
    step();
    obs = status();
    n_checks++;
    if (obs !== 5'b101_00) begin
      n_fail++;
      $display("FAIL rering_after_reset got=%b want=%b", obs, 5'b101_00);
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    reset             = 1'b0;
    bus.sec_tick      = 1'b0;
    bus.cur_hour      = 7'd6;
    bus.cur_minute    = 7'd29;
    bus.alarm_hour    = 7'd6;
    bus.alarm_minute  = 7'd30;
    bus.alarm_set     = 1'b1;
    bus.stop_signal   = 1'b0;
    bus.snooze_signal = 1'b0;
    test_reset();
    test_ring_pattern();
    test_snooze();
    test_max_snooze();
    test_timeout();
    test_tick_vs_button();
    test_stop_and_snooze();
    test_drop_set();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
